// File: rtl/uart_cmd_decode_if.sv
// Byte strobe in, write-FIFO push/flush and command trigger pulses out.
// Latency: none, this is wiring only.
// Backpressure: none; the receiver side cannot be stalled.
interface uart_cmd_decode_if;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wfifo_clr;
    logic       wr_trig;
    logic       rd_trig;
    logic       frame_err;

    // Byte source side (UART receiver / testbench)
    modport master (
        output rx_data, rx_flag,
        input  wfifo_wr_en, wfifo_data, wfifo_clr, wr_trig, rd_trig, frame_err
    );

    // Decoder side
    modport slave (
        input  rx_data, rx_flag,
        output wfifo_wr_en, wfifo_data, wfifo_clr, wr_trig, rd_trig, frame_err
    );
endinterface

// File: rtl/uart_cmd_decode.sv
// Frames UART bytes into write (cmd + PAYLOAD_LEN bytes) or read commands.
// Latency: pushes/rd_trig/frame_err 1 cycle after rx_flag; wr_trig 2 cycles after last byte.
// Backpressure: none; every strobed byte is consumed, stalled frames abort on timeout.
module uart_cmd_decode #(
    parameter int         PAYLOAD_LEN = 5,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] CMD_WR      = 8'h55,
    parameter logic [7:0] CMD_RD      = 8'hAA
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_decode_if.slave   bus
);

    localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    // Last byte index of the payload, and the counter value one cycle before
    // the abort so the registered pulse lands TIMEOUT_CYC cycles after the byte.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_ABORT = TMO_W'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       data_q, data_d;
    logic             clr_q, clr_d;
    logic             wr_trig_q, wr_trig_d;
    logic             rd_trig_q, rd_trig_d;
    logic             err_q, err_d;
    logic             cmd_en;

    // State, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            data_q    <= 8'h00;
            clr_q     <= 1'b0;
            wr_trig_q <= 1'b0;
            rd_trig_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            clr_q     <= clr_d;
            wr_trig_q <= wr_trig_d;
            rd_trig_q <= rd_trig_d;
            err_q     <= err_d;
        end
    end

    // Next-state and next-output decode; DONE also accepts a new command byte
    // so a frame arriving right behind a completed write is not lost.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        clr_d     = 1'b0;
        wr_trig_d = 1'b0;
        rd_trig_d = 1'b0;
        err_d     = 1'b0;
        cmd_en    = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_en = 1'b1;
            end
            PAYLOAD: begin
                if (bus.rx_flag) begin
                    // A byte always beats a coinciding timeout
                    wr_en_d = 1'b1;
                    data_d  = bus.rx_data;
                    tmo_d   = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_ABORT) begin
                    clr_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                wr_trig_d = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
                tmo_d     = '0;
                cmd_en    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tmo_d   = '0;
            end
        endcase

        if (cmd_en && bus.rx_flag) begin
            if (bus.rx_data == CMD_WR) begin
                state_d = PAYLOAD;
                cnt_d   = '0;
                tmo_d   = '0;
            end else if (bus.rx_data == CMD_RD) begin
                rd_trig_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign bus.wfifo_wr_en = wr_en_q;
    assign bus.wfifo_data  = data_q;
    assign bus.wfifo_clr   = clr_q;
    assign bus.wr_trig     = wr_trig_q;
    assign bus.rd_trig     = rd_trig_q;
    assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Bench for uart_cmd_decode: directed frames plus random byte stream.
// Latency: expected per-cycle outputs come from a frame-level reference model.
// Backpressure: none exercised; the decoder has no stall input.
module tb_uart_cmd_decode;

    localparam int PLEN  = 5;
    localparam int TMO   = 600;
    localparam int NCYC  = 40000;

    logic clk;
    logic rst;

    uart_cmd_decode_if bus();

    uart_cmd_decode #(
        .PAYLOAD_LEN (PLEN),
        .TIMEOUT_CYC (TMO),
        .CMD_WR      (8'h55),
        .CMD_RD      (8'hAA)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus schedule, indexed by cycle
    bit       s_vld [NCYC];
    bit [7:0] s_dat [NCYC];
    bit       s_rst [NCYC];

    // Expected outputs, indexed by cycle
    bit       e_wr  [NCYC];
    bit [7:0] e_dat [NCYC];
    bit       e_clr [NCYC];
    bit       e_wt  [NCYC];
    bit       e_rd  [NCYC];
    bit       e_err [NCYC];

    int n_chk  = 0;
    int n_pass = 0;
    int cur_cyc = 0;
    int t = 10;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cur_cyc, got, exp);
    endtask

    task automatic add(input bit [7:0] b, input int gap);
        t = t + gap;
        s_vld[t] = 1'b1;
        s_dat[t] = b;
    endtask

    task automatic add_rst();
        t = t + 5;
        s_rst[t]   = 1'b1;
        s_rst[t+1] = 1'b1;
        t = t + 6;
    endtask

    // Frame-level reference: walks the byte list, tracks the open frame by its
    // last byte time and byte count, and places each pulse at its cycle.
    task automatic run_model();
        bit in_frame = 1'b0;
        int last = 0;
        int cnt = 0;
        for (int k = 0; k < NCYC; k++) begin
            if (in_frame && k >= last + TMO) begin
                e_clr[last+TMO] = 1'b1;
                e_err[last+TMO] = 1'b1;
                in_frame = 1'b0;
            end
            if (s_rst[k]) begin
                in_frame = 1'b0;
            end else if (s_vld[k]) begin
                if (in_frame) begin
                    if (k + 1 < NCYC) begin
                        e_wr[k+1]  = 1'b1;
                        e_dat[k+1] = s_dat[k];
                    end
                    cnt++;
                    last = k;
                    if (cnt == PLEN) begin
                        if (k + 2 < NCYC) e_wt[k+2] = 1'b1;
                        in_frame = 1'b0;
                    end
                end else if (s_dat[k] == 8'h55) begin
                    in_frame = 1'b1;
                    last = k;
                    cnt = 0;
                end else if (s_dat[k] == 8'hAA) begin
                    if (k + 1 < NCYC) e_rd[k+1] = 1'b1;
                end else begin
                    if (k + 1 < NCYC) e_err[k+1] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_flag = 1'b0;
        bus.rx_data = 8'h00;

        s_rst[0] = 1'b1;
        s_rst[1] = 1'b1;
        s_rst[2] = 1'b1;

        // Write frame, wide spacing below the timeout
        add(8'h55, 1);
        for (int i = 1; i <= 5; i++) add(8'(i), 560);
        // Read, then a write frame whose payload is all command values
        add(8'hAA, 50);
        add(8'h55, 20);
        for (int i = 0; i < 5; i++) add((i % 2 == 0) ? 8'hAA : 8'h55, 3 + i);
        // Unknown command, then a normal frame
        add(8'h3C, 20);
        add(8'h55, 4);
        for (int i = 0; i < 5; i++) add(8'hA0 + 8'(i), 2);
        // Timeout after two payload bytes, then a read
        add(8'h55, 20);
        add(8'h11, 7);
        add(8'h22, 9);
        add(8'hAA, 700);
        // Byte exactly on the last allowed cycle wins
        add(8'h55, 20);
        add(8'h11, TMO - 1);
        add(8'h22, TMO - 1);
        add(8'h33, TMO - 1);
        add(8'h44, 1);
        add(8'h66, TMO - 1);
        // One cycle too late: abort, then the byte is a command
        add(8'h55, 20);
        add(8'h11, TMO);
        // Command right behind the last payload byte (lands in DONE)
        add(8'h55, 20);
        for (int i = 1; i <= 5; i++) add(8'(i), 1);
        add(8'h55, 1);
        for (int i = 1; i <= 5; i++) add(8'hF0 + 8'(i), 1);
        add(8'hAA, 1);
        // Reset mid-frame, then a complete frame
        add(8'h55, 20);
        add(8'h11, 3);
        add_rst();
        add(8'h55, 1);
        for (int i = 1; i <= 5; i++) add(8'(i), 2);
        t = t + 20;

        // Random byte stream, biased toward command values
        while (t < NCYC - 1500) begin
            int sel;
            bit [7:0] b;
            int gap;
            sel = $urandom_range(0, 3);
            b = (sel == 0) ? 8'h55 : (sel == 1) ? 8'hAA : 8'($urandom_range(0, 255));
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(595, 605) : $urandom_range(1, 12);
            add(b, gap);
        end

        run_model();

        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            cur_cyc = k;
            if (k >= 1) begin
                chk("pulses",
                    {27'd0, bus.wfifo_wr_en, bus.wfifo_clr, bus.wr_trig, bus.rd_trig, bus.frame_err},
                    {27'd0, e_wr[k], e_clr[k], e_wt[k], e_rd[k], e_err[k]});
                if (e_wr[k]) chk("wdata", {24'd0, bus.wfifo_data}, {24'd0, e_dat[k]});
                if (s_rst[k-1]) chk("rst_data", {24'd0, bus.wfifo_data}, 32'd0);
            end
            rst         = s_rst[k];
            bus.rx_flag = s_vld[k];
            bus.rx_data = s_vld[k] ? s_dat[k] : 8'($urandom_range(0, 255));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decode.md
# uart_cmd_decode

Byte-level command parser between `uart_rx` and the SDRAM write/read arbitration in `top`. Consumes the one-cycle byte strobes from the UART receiver and frames them into write or read commands. For writes, it streams the payload bytes into the write FIFO and then pulses a write trigger. For reads, it pulses a read trigger. Incomplete frames are aborted on an inter-byte timeout and the partial FIFO content is flushed.

## Interface
Parameters:
- `PAYLOAD_LEN`, 5: data bytes following a write command byte. A full write frame is 6 bytes.
- `TIMEOUT_CYC`, 50000: maximum clock cycles between bytes of one frame (1 ms at 50 MHz). Benches override it, e.g. to 600.
- `CMD_WR`, 8'h55: write command byte.
- `CMD_RD`, 8'hAA: read command byte.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain). One clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte, valid when `rx_flag`=1.
- `rx_flag`  in  1  one-cycle byte-valid strobe from `uart_rx`.
- `wfifo_wr_en`  out  1  write-FIFO push strobe.
- `wfifo_data`  out  8  byte to push; valid with `wfifo_wr_en`.
- `wfifo_clr`  out  1  one-cycle FIFO flush on abort.
- `wr_trig`  out  1  one-cycle pulse: a full payload is in the FIFO.
- `rd_trig`  out  1  one-cycle pulse: read command received.
- `frame_err`  out  1  one-cycle pulse: unknown command byte or timeout.

## Operation
- States: IDLE, PAYLOAD, DONE.
- IDLE, on `rx_flag`:
  - `rx_data`==CMD_WR: go to PAYLOAD, byte counter=0, timeout counter=0.
  - `rx_data`==CMD_RD: `rd_trig` pulses, stay in IDLE.
  - Any other byte: `frame_err` pulses, stay in IDLE.
- PAYLOAD, on `rx_flag`:
  - Push the byte (`wfifo_wr_en`=1, `wfifo_data`=`rx_data`), increment the byte counter, clear the timeout counter.
  - Every byte value is payload, including 0x55 and 0xAA.
  - On byte number PAYLOAD_LEN, go to DONE.
- PAYLOAD, without `rx_flag`: the timeout counter increments. When it reaches TIMEOUT_CYC-1, pulse `wfifo_clr` and `frame_err` together, then go to IDLE.
- DONE: pulse `wr_trig`, then go to IDLE unconditionally.
- Byte counter width is clog2(PAYLOAD_LEN+1). Timeout counter width is clog2(TIMEOUT_CYC). Neither counter wraps; both are cleared on every state entry.
- No back-pressure input. The FIFO is sized by the owner of `top` to hold at least PAYLOAD_LEN bytes.

## Timing
- Reset: state=IDLE, both counters=0. `wfifo_wr_en`, `wfifo_clr`, `wr_trig`, `rd_trig`, `frame_err` are all 0, and `wfifo_data`=8'h00.
- All outputs are registered. For an `rx_flag` in cycle N:
  - `wfifo_wr_en`/`wfifo_data`, `rd_trig` and `frame_err` (unknown command) are asserted in cycle N+1.
  - For the last payload byte, `wfifo_wr_en` is in cycle N+1 and `wr_trig` in cycle N+2. `wr_trig` is never coincident with a push.
- Timeout: counting starts the cycle after the last accepted byte. Abort pulses appear TIMEOUT_CYC cycles after that byte's `rx_flag`.
- Simultaneous byte and timeout in the same cycle: the byte wins. It is pushed, the counter clears, and there is no abort.
- `rx_flag` while in DONE: the byte is parsed as an IDLE command in the same cycle. `wr_trig` is still issued, so the next frame is never lost.
- `rst` mid-frame: return to IDLE next cycle and drop all pulses. No `wfifo_clr` is issued; the FIFO is reset by the same `rst`.
- Every pulse output is exactly one cycle wide.

## Test plan
- Write frame: bytes 55 01 02 03 04 05, 560-cycle spacing -> five pushes with data 01..05 in order, then one `wr_trig` 1 cycle after the push of 05. No `frame_err`.
- Read: byte AA -> `rd_trig` 1 cycle after `rx_flag`, no push. Then 55 AA 55 AA 55 AA -> AA 55 AA 55 AA pushed as payload and one `wr_trig`. No `rd_trig` for the payload AA bytes.
- Unknown command: byte 3C in IDLE -> `frame_err` 1 cycle later, no push or triggers. A following 55 frame is parsed normally.
- Timeout (TIMEOUT_CYC=600): 55 11 22, then silence -> two pushes, then `wfifo_clr`+`frame_err` 600 cycles after the 22 strobe, no `wr_trig`. A byte AA afterwards -> `rd_trig`.
- Boundary: `rx_flag` exactly at timeout cycle 599 -> byte pushed, no abort. `rst` asserted after 55 11 -> all outputs 0 next cycle, and a following 55 01..05 frame completes with `wr_trig`.
